sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter.
//   Bit_t            - single control bit
//   Word_t           - 32-bit bus word
//   SRAM_ADDR_WIDTH  - SRAM word-address width (addr[21:2] of a byte address)
//   sram_arb_state_t - arbiter FSM states
package sram_arbiter_pkg;

  typedef logic        Bit_t;
  typedef logic [31:0] Word_t;

  localparam int SRAM_ADDR_WIDTH = 20;

  typedef logic [SRAM_ADDR_WIDTH-1:0] SramAddr_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } sram_arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single asynchronous
// 32-bit SRAM. One transaction is in flight at a time; simultaneous requests
// are granted round-robin, the data port winning first after reset.
//
// Ports
//   clk, rst                  - system clock, asynchronous active-low reset
//   ibus_req/addr/rdata/ack   - instruction port, reads only
//   dbus_req/we/be/addr/wdata/rdata/ack - data port, reads and byte writes
//   sram_addr                 - SRAM word address (byte address bits [21:2])
//   sram_data_o/_oe/_i        - SRAM data bus, split for an external tristate
//   sram_ce_n/oe_n/we_n/be_n  - active-low SRAM strobes
//
// Every SRAM pin and ack is a flop. The strobe/ack flops are loaded from the
// current FSM state, so the pins lag the state by one cycle: the address is
// latched on the grant edge and is therefore stable one cycle before any
// strobe goes low, and read data is sampled on the edge that closes the last
// oe_n-low cycle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int READ_WAIT = 1,  // extra read cycles beyond the first (0..7)
  parameter int WE_PULSE  = 1   // we_n low cycles per write (1..7)
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_rdata,
  output logic        ibus_ack,

  input  logic        dbus_req,
  input  logic        dbus_we,
  input  logic [3:0]  dbus_be,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ack,

  output logic [19:0] sram_addr,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe,
  input  logic [31:0] sram_data_i,

  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  localparam logic [2:0] LP_RD_LAST = 3'(READ_WAIT);
  localparam logic [2:0] LP_WE_LAST = 3'(WE_PULSE - 1);

  sram_arb_state_t r_state;
  sram_arb_state_t w_next;
  logic [2:0]      r_wait;

  Bit_t            w_grant;
  Bit_t            w_grant_d;
  Bit_t            r_prio_d;   // 1: dbus wins the next tie
  Bit_t            r_port_d;   // port owning the transaction in flight
  Bit_t            r_we;
  logic [3:0]      r_be;
  SramAddr_t       r_sram_addr;
  Word_t           r_data_o;
  Word_t           r_ibus_rdata;
  Word_t           r_dbus_rdata;
  Bit_t            r_ibus_ack;
  Bit_t            r_dbus_ack;
  Bit_t            r_ce_n;
  Bit_t            r_oe_n;
  Bit_t            r_we_n;
  logic [3:0]      r_be_n;
  Bit_t            r_data_oe;

  // Address bits outside the SRAM word range carry no meaning here.
  logic w_unused;
  assign w_unused = ^{ibus_addr[31:22], ibus_addr[1:0],
                      dbus_addr[31:22], dbus_addr[1:0]};

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (ibus_req || dbus_req) begin
          w_grant   = 1'b1;
          w_grant_d = dbus_req && (!ibus_req || r_prio_d);
          w_next    = (w_grant_d && dbus_we) ? WR_SETUP : RD;
        end
      end
      RD:       if (r_wait == LP_RD_LAST) w_next = ACK;
      WR_SETUP: w_next = WR_PULSE;
      WR_PULSE: if (r_wait == LP_WE_LAST) w_next = WR_HOLD;
      WR_HOLD:  w_next = ACK;
      ACK:      w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wait  <= 3'd0;
    end else begin
      r_state <= w_next;
      // Counts cycles spent in the current timed state; zero on entry.
      if ((w_next == r_state) && ((r_state == RD) || (r_state == WR_PULSE)))
        r_wait <= r_wait + 3'd1;
      else
        r_wait <= 3'd0;
    end
  end

  // Transaction operands, latched once on the grant edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio_d    <= 1'b1;
      r_port_d    <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'h0;
      r_sram_addr <= '0;
      r_data_o    <= '0;
    end else if (w_grant) begin
      r_prio_d    <= !w_grant_d;
      r_port_d    <= w_grant_d;
      r_we        <= w_grant_d && dbus_we;
      r_be        <= w_grant_d ? dbus_be : 4'h0;
      r_sram_addr <= w_grant_d ? dbus_addr[21:2] : ibus_addr[21:2];
      if (w_grant_d)
        r_data_o <= dbus_wdata;
    end
  end

  // Pin and ack flops, one cycle behind the state they decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_be_n       <= 4'hF;
      r_data_oe    <= 1'b0;
      r_ibus_ack   <= 1'b0;
      r_dbus_ack   <= 1'b0;
      r_ibus_rdata <= '0;
      r_dbus_rdata <= '0;
    end else begin
      r_ce_n     <= !((r_state == RD) || (r_state == WR_SETUP) ||
                      (r_state == WR_PULSE) || (r_state == WR_HOLD));
      r_oe_n     <= (r_state != RD);
      r_we_n     <= (r_state != WR_PULSE);
      r_data_oe  <= (r_state == WR_SETUP) || (r_state == WR_PULSE) ||
                    (r_state == WR_HOLD);
      if (r_state == RD)
        r_be_n <= 4'h0;
      else if ((r_state == WR_SETUP) || (r_state == WR_PULSE) ||
               (r_state == WR_HOLD))
        r_be_n <= ~r_be;
      else
        r_be_n <= 4'hF;
      r_ibus_ack <= (r_state == ACK) && !r_port_d;
      r_dbus_ack <= (r_state == ACK) &&  r_port_d;
      // The edge leaving ACK closes the final oe_n-low cycle of a read.
      if ((r_state == ACK) && !r_we) begin
        if (r_port_d)
          r_dbus_rdata <= sram_data_i;
        else
          r_ibus_rdata <= sram_data_i;
      end
    end
  end

  assign sram_addr    = r_sram_addr;
  assign sram_data_o  = r_data_o;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;
  assign ibus_rdata   = r_ibus_rdata;
  assign ibus_ack     = r_ibus_ack;
  assign dbus_rdata   = r_dbus_rdata;
  assign dbus_ack     = r_dbus_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default-parameter instance plus a
// READ_WAIT=3 / WE_PULSE=2 instance, each with a small behavioural SRAM.
module tb_sram_arbiter;

  logic        clk, rst;

  logic        ibus_req, ibus_ack, dbus_req, dbus_we, dbus_ack;
  logic [31:0] ibus_addr, ibus_rdata, dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be, sram_be_n;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic        ibus_req2, ibus_ack2, dbus_req2, dbus_we2, dbus_ack2;
  logic [31:0] ibus_addr2, ibus_rdata2, dbus_addr2, dbus_wdata2, dbus_rdata2;
  logic [3:0]  dbus_be2, sram_be_n2;
  logic [19:0] sram_addr2;
  logic [31:0] sram_data_o2, sram_data_i2;
  logic        sram_data_oe2, sram_ce_n2, sram_oe_n2, sram_we_n2;

  logic [31:0] mem1 [0:63];
  logic [31:0] mem2 [0:63];

  int n_chk  = 0;
  int n_fail = 0;

  sram_arbiter u_dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_rdata(ibus_rdata), .ibus_ack(ibus_ack),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  sram_arbiter #(.READ_WAIT(3), .WE_PULSE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req2), .ibus_addr(ibus_addr2), .ibus_rdata(ibus_rdata2), .ibus_ack(ibus_ack2),
    .dbus_req(dbus_req2), .dbus_we(dbus_we2), .dbus_be(dbus_be2), .dbus_addr(dbus_addr2),
    .dbus_wdata(dbus_wdata2), .dbus_rdata(dbus_rdata2), .dbus_ack(dbus_ack2),
    .sram_addr(sram_addr2), .sram_data_o(sram_data_o2), .sram_data_oe(sram_data_oe2),
    .sram_data_i(sram_data_i2), .sram_ce_n(sram_ce_n2), .sram_oe_n(sram_oe_n2),
    .sram_we_n(sram_we_n2), .sram_be_n(sram_be_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: contents preloaded while reset is low, byte writes
  // while ce_n/we_n are low.
  assign sram_data_i  = mem1[sram_addr[5:0]];
  assign sram_data_i2 = mem2[sram_addr2[5:0]];

  always @(posedge clk) begin
    if (!rst) begin
      mem1[0]  <= 32'h0;
      mem1[4]  <= 32'hDEADBEEF;
      mem1[8]  <= 32'hAAAAAAAA;
      mem1[9]  <= 32'h99999999;
      mem1[12] <= 32'h0;
      mem1[16] <= 32'h11110000;
      mem1[17] <= 32'h22220000;
      mem1[18] <= 32'h33330000;
      mem2[0]  <= 32'h0;
      mem2[4]  <= 32'hCAFEF00D;
      mem2[5]  <= 32'h0;
    end else begin
      if (!sram_ce_n && !sram_we_n && sram_data_oe)
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) mem1[sram_addr[5:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
      if (!sram_ce_n2 && !sram_we_n2 && sram_data_oe2)
        for (int b = 0; b < 4; b++)
          if (!sram_be_n2[b]) mem2[sram_addr2[5:0]][8*b +: 8] <= sram_data_o2[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit d2, input bit ib, input bit req, input bit we,
                       input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
    if (d2) begin
      dbus_req2 = req; dbus_we2 = we; dbus_be2 = be; dbus_addr2 = addr; dbus_wdata2 = wd;
    end else if (ib) begin
      ibus_req = req; ibus_addr = addr;
    end else begin
      dbus_req = req; dbus_we = we; dbus_be = be; dbus_addr = addr; dbus_wdata = wd;
    end
  endtask

  // Results of the last transfer; edge indices counted from the grant edge (0).
  int          t_ack, t_oe, t_we, t_doe;
  logic [19:0] t_a;
  logic [3:0]  t_be;
  logic [31:0] t_dout;
  bit          t_oth, t_wide;

  task automatic xfer(input bit d2, input bit ib, input bit we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wd, input bit drop_early);
    logic ack_me, ack_oth;
    t_ack = -1; t_oe = 0; t_we = 0; t_doe = 0; t_oth = 0;
    t_a = '0; t_be = 4'hF; t_dout = '0;
    drive(d2, ib, 1'b1, we, be, addr, wd);
    for (int k = 0; k < 40 && t_ack < 0; k++) begin
      @(posedge clk); #1;
      if (drop_early && k == 1) drive(d2, ib, 1'b0, we, be, addr, wd);
      ack_me  = d2 ? dbus_ack2 : (ib ? ibus_ack : dbus_ack);
      ack_oth = d2 ? 1'b0      : (ib ? dbus_ack : ibus_ack);
      if (d2) begin
        if (!sram_oe_n2) t_oe++;
        if (!sram_we_n2) t_we++;
        if (sram_data_oe2) begin t_doe++; t_dout = sram_data_o2; end
        if (!sram_ce_n2) t_be = sram_be_n2;
        if (k == 0) t_a = sram_addr2;
      end else begin
        if (!sram_oe_n) t_oe++;
        if (!sram_we_n) t_we++;
        if (sram_data_oe) begin t_doe++; t_dout = sram_data_o; end
        if (!sram_ce_n) t_be = sram_be_n;
        if (k == 0) t_a = sram_addr;
      end
      if (ack_oth) t_oth = 1'b1;
      if (ack_me) begin
        t_ack = k;
        drive(d2, ib, 1'b0, we, be, addr, wd);
      end
    end
    @(posedge clk); #1;
    t_wide = d2 ? dbus_ack2 : (ib ? ibus_ack : dbus_ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  int   n_ack, pend;
  int   ack_cyc [4];
  bit   ack_port [4];
  bit   both, idle_ok, saw_we, saw_ack;

  initial begin
    rst = 1'b0;
    ibus_req = 0; ibus_addr = '0; dbus_req = 0; dbus_we = 0; dbus_be = '0;
    dbus_addr = '0; dbus_wdata = '0;
    ibus_req2 = 0; ibus_addr2 = '0; dbus_req2 = 0; dbus_we2 = 0; dbus_be2 = '0;
    dbus_addr2 = '0; dbus_wdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_data_oe", sram_data_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data_o", sram_data_o, 0);
    chk("rst_rdata", ibus_rdata | dbus_rdata, 0);
    chk("rst_acks", {ibus_ack, dbus_ack}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // dbus read of word 4
    xfer(0, 0, 0, 4'h0, 32'h0000_0010, 32'h0, 0);
    chk("rd_addr", t_a, 20'd4);
    chk("rd_oe_cycles", t_oe, 2);
    chk("rd_ack_lat", t_ack, 3);
    chk("rd_data", dbus_rdata, 32'hDEADBEEF);
    chk("rd_ack_pulse", t_wide, 0);
    chk("rd_other_ack", t_oth, 0);
    chk("rd_ibus_rdata", ibus_rdata, 0);

    // dbus write, lower two bytes
    xfer(0, 0, 1, 4'b0011, 32'h0000_0020, 32'h12345678, 0);
    chk("wr_addr", t_a, 20'd8);
    chk("wr_be_n", t_be, 4'b1100);
    chk("wr_we_cycles", t_we, 1);
    chk("wr_doe_cycles", t_doe, 3);
    chk("wr_oe_cycles", t_oe, 0);
    chk("wr_data_o", t_dout, 32'h12345678);
    chk("wr_ack_lat", t_ack, 4);
    chk("wr_ack_pulse", t_wide, 0);
    chk("wr_mem", mem1[8], 32'hAAAA5678);
    chk("wr_rdata_kept", dbus_rdata, 32'hDEADBEEF);

    xfer(0, 0, 0, 4'h0, 32'h0000_0020, 32'h0, 0);
    chk("rdback_data", dbus_rdata, 32'hAAAA5678);

    // high and low address bits ignored
    xfer(0, 0, 0, 4'h0, 32'hFFC0_0013, 32'h0, 0);
    chk("addr_mask", t_a, 20'd4);
    chk("addr_mask_data", dbus_rdata, 32'hDEADBEEF);

    // write with no byte enables
    xfer(0, 0, 1, 4'b0000, 32'h0000_0024, 32'hFFFFFFFF, 0);
    chk("be0_be_n", t_be, 4'hF);
    chk("be0_ack_lat", t_ack, 4);
    chk("be0_mem", mem1[9], 32'h99999999);

    // reset asserted while we_n is low
    saw_we = 0;
    drive(0, 0, 1, 1, 4'hF, 32'h0000_0030, 32'h00000055);
    for (int k = 0; k < 20 && !saw_we; k++) begin
      @(posedge clk); #1;
      if (!sram_we_n) saw_we = 1;
    end
    chk("abort_reached_pulse", saw_we, 1);
    #3 rst = 1'b0;
    #1;
    chk("abort_we_n", sram_we_n, 1);
    chk("abort_data_oe", sram_data_oe, 0);
    chk("abort_ce_n", sram_ce_n, 1);
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    saw_ack = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dbus_ack || ibus_ack) saw_ack = 1;
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (dbus_ack || ibus_ack) saw_ack = 1;
    end
    chk("abort_no_ack", saw_ack, 0);
    chk("abort_rdata_rst", dbus_rdata, 0);
    xfer(0, 0, 0, 4'h0, 32'h0000_0010, 32'h0, 0);
    chk("post_abort_lat", t_ack, 3);
    chk("post_abort_data", dbus_rdata, 32'hDEADBEEF);

    // round robin from reset with both requests held
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_ack = 0; pend = -1; both = 0; idle_ok = 1;
    for (int i = 0; i < 4; i++) begin ack_cyc[i] = 0; ack_port[i] = 0; end
    ibus_req = 1; ibus_addr = 32'h0000_0040;
    dbus_req = 1; dbus_we = 0; dbus_addr = 32'h0000_0044;
    for (int c = 0; c < 60 && n_ack < 4; c++) begin
      @(posedge clk); #1;
      if (c == pend && (sram_ce_n !== 1'b1 || sram_data_oe !== 1'b0)) idle_ok = 0;
      if (ibus_ack && dbus_ack) both = 1;
      if (ibus_ack || dbus_ack) begin
        ack_port[n_ack] = dbus_ack;
        ack_cyc[n_ack]  = c;
        n_ack++;
        pend = c + 1;
      end
    end
    ibus_req = 0; dbus_req = 0;
    @(posedge clk); #1;
    if (pend >= 0 && (sram_ce_n !== 1'b1 || sram_data_oe !== 1'b0)) idle_ok = 0;
    chk("rr_ack_count", n_ack, 4);
    chk("rr_order", {ack_port[0], ack_port[1], ack_port[2], ack_port[3]}, 4'b1010);
    for (int i = 1; i < 4; i++)
      chk($sformatf("rr_spacing%0d", i), ack_cyc[i] - ack_cyc[i-1], 4);
    chk("rr_single_ack", both, 0);
    chk("rr_idle_gap", idle_ok, 1);
    chk("rr_ibus_data", ibus_rdata, 32'h11110000);
    chk("rr_dbus_data", dbus_rdata, 32'h22220000);

    // ibus request dropped right after grant
    xfer(0, 1, 0, 4'h0, 32'h0000_0048, 32'h0, 1);
    chk("drop_ack_lat", t_ack, 3);
    chk("drop_ack_pulse", t_wide, 0);
    chk("drop_ibus_data", ibus_rdata, 32'h33330000);
    chk("drop_dbus_ack", t_oth, 0);
    chk("drop_dbus_data", dbus_rdata, 32'h22220000);

    // longer read and write timing
    xfer(1, 0, 0, 4'h0, 32'h0000_0010, 32'h0, 0);
    chk("p2_rd_oe_cycles", t_oe, 4);
    chk("p2_rd_ack_lat", t_ack, 5);
    chk("p2_rd_data", dbus_rdata2, 32'hCAFEF00D);
    xfer(1, 0, 1, 4'hF, 32'h0000_0014, 32'h0BADF00D, 0);
    chk("p2_wr_addr", t_a, 20'd5);
    chk("p2_wr_we_cycles", t_we, 2);
    chk("p2_wr_doe_cycles", t_doe, 4);
    chk("p2_wr_data_o", t_dout, 32'h0BADF00D);
    chk("p2_wr_ack_lat", t_ack, 5);
    chk("p2_wr_mem", mem2[5], 32'h0BADF00D);
    chk("p2_ibus_idle", ibus_rdata2 | {31'h0, ibus_ack2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
